// File: rtl/pc_redirect_unit_pkg.sv
// ============================================================================
// pc_pkg : shared encodings, FSM state type and helpers for pc_redirect_unit
// Rev 1.0
// ============================================================================
`default_nettype none

package pc_pkg;

   localparam logic [2:0] OP_NONE   = 3'd0;
   localparam logic [2:0] OP_BRANCH = 3'd1;
   localparam logic [2:0] OP_JAL    = 3'd2;
   localparam logic [2:0] OP_JALR   = 3'd3;
   localparam logic [2:0] OP_MRET   = 3'd4;

   localparam logic [2:0] F3_BEQ  = 3'd0;
   localparam logic [2:0] F3_BNE  = 3'd1;
   localparam logic [2:0] F3_BLT  = 3'd4;
   localparam logic [2:0] F3_BGE  = 3'd5;
   localparam logic [2:0] F3_BLTU = 3'd6;
   localparam logic [2:0] F3_BGEU = 3'd7;

   localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0100;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      SQUASH = 1'b1
   } state_t;

   // Saturating event counter step: sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pc_redirect_unit_if.sv
// ============================================================================
// pc_redirect_unit_if : EX-slot inputs and PC-register redirect outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface pc_redirect_unit_if #(
   parameter int XLEN = 32
);
   logic            ex_valid;
   logic [2:0]      ex_op;
   logic [2:0]      ex_funct3;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_rs1;
   logic [XLEN-1:0] ex_rs2;
   logic [XLEN-1:0] ex_imm;
   logic            irq_req;

   logic            br_ctrl;
   logic [XLEN-1:0] br_addr;
   logic            ret_ctrl;
   logic [XLEN-1:0] ret_pc;
   logic            flush;
   logic            irq_ack;
   logic            in_trap;

   modport master (
      output ex_valid, ex_op, ex_funct3, ex_pc, ex_rs1, ex_rs2, ex_imm, irq_req,
      input  br_ctrl, br_addr, ret_ctrl, ret_pc, flush, irq_ack, in_trap
   );

   modport slave (
      input  ex_valid, ex_op, ex_funct3, ex_pc, ex_rs1, ex_rs2, ex_imm, irq_req,
      output br_ctrl, br_addr, ret_ctrl, ret_pc, flush, irq_ack, in_trap
   );

endinterface

`default_nettype wire

// File: rtl/pc_redirect_unit_br_cond_eval.sv
// ============================================================================
// br_cond_eval : combinational branch-condition compare selected by funct3
// Rev 1.0
// ============================================================================
`default_nettype none

module br_cond_eval
   import pc_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            taken
);

   logic w_eq;
   logic w_lt;
   logic w_ltu;

   assign w_eq  = (rs1 == rs2);
   assign w_lt  = ($signed(rs1) < $signed(rs2));
   assign w_ltu = (rs1 < rs2);

   always_comb begin
      taken = 1'b0;
      case (funct3)
         F3_BEQ:  taken = w_eq;
         F3_BNE:  taken = ~w_eq;
         F3_BLT:  taken = w_lt;
         F3_BGE:  taken = ~w_lt;
         F3_BLTU: taken = w_ltu;
         F3_BGEU: taken = ~w_ltu;
         default: taken = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/pc_redirect_unit.sv
// ============================================================================
// pc_redirect_unit : EX-stage branch/jump/MRET/IRQ resolver with wrong-path squash
// Optional event counters when PC_REDIRECT_STATS_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module pc_redirect_unit
   import pc_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(TRAP_VEC_DEFAULT),
   parameter int              SQUASH_CYC = 2
) (
   input  logic              clk,
   input  logic              rstn,
   pc_redirect_unit_if.slave bus
`ifdef PC_REDIRECT_STATS_EN
   ,
   output logic [31:0]       cnt_branch_taken,
   output logic [31:0]       cnt_jump,
   output logic [31:0]       cnt_irq,
   output logic [31:0]       cnt_mret
`endif
);

   localparam logic [1:0] SQ_LOAD = 2'(SQUASH_CYC - 1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [1:0]      r_sq_cnt;
   logic [1:0]      w_sq_cnt_nxt;

   logic            r_br_ctrl;
   logic [XLEN-1:0] r_br_addr;
   logic            r_ret_ctrl;
   logic [XLEN-1:0] r_ret_pc;
   logic            r_irq_ack;
   logic            r_in_trap;
   logic [XLEN-1:0] r_mepc;
   logic [XLEN-1:0] r_last_pc;

   logic            w_taken;
   logic            w_cf_br;
   logic            w_cf_jmp;
   logic [XLEN-1:0] w_pc_sum;
   logic [XLEN-1:0] w_jalr_sum;
   logic [XLEN-1:0] w_target;

   logic            w_br;
   logic [XLEN-1:0] w_br_addr;
   logic            w_ret;
   logic            w_ack;
   logic            w_ev_branch;
   logic            w_ev_jump;

   br_cond_eval #(.XLEN(XLEN)) u_br_cond_eval (
      .funct3 (bus.ex_funct3),
      .rs1    (bus.ex_rs1),
      .rs2    (bus.ex_rs2),
      .taken  (w_taken)
   );

   assign w_cf_br    = bus.ex_valid && (bus.ex_op == OP_BRANCH) && w_taken;
   assign w_cf_jmp   = bus.ex_valid && ((bus.ex_op == OP_JAL) || (bus.ex_op == OP_JALR));
   assign w_pc_sum   = bus.ex_pc + bus.ex_imm;
   assign w_jalr_sum = bus.ex_rs1 + bus.ex_imm;
   assign w_target   = (bus.ex_op == OP_JALR) ? {w_jalr_sum[XLEN-1:1], 1'b0} : w_pc_sum;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= IDLE;
         r_sq_cnt <= 2'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_sq_cnt <= w_sq_cnt_nxt;
      end
   end

   // EX control flow outranks MRET, which outranks IRQ entry; every pulse enters SQUASH.
   always_comb begin
      w_state_nxt  = r_state;
      w_sq_cnt_nxt = r_sq_cnt;
      w_br         = 1'b0;
      w_br_addr    = '0;
      w_ret        = 1'b0;
      w_ack        = 1'b0;
      w_ev_branch  = 1'b0;
      w_ev_jump    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_cf_br || w_cf_jmp) begin
               w_br         = 1'b1;
               w_br_addr    = w_target;
               w_ev_branch  = w_cf_br;
               w_ev_jump    = w_cf_jmp;
               w_state_nxt  = SQUASH;
               w_sq_cnt_nxt = SQ_LOAD;
            end else if (bus.ex_valid && (bus.ex_op == OP_MRET) && r_in_trap) begin
               w_ret        = 1'b1;
               w_state_nxt  = SQUASH;
               w_sq_cnt_nxt = SQ_LOAD;
            end else if (bus.irq_req && !r_in_trap) begin
               w_br         = 1'b1;
               w_br_addr    = TRAP_VEC;
               w_ack        = 1'b1;
               w_state_nxt  = SQUASH;
               w_sq_cnt_nxt = SQ_LOAD;
            end
         end
         SQUASH: begin
            if (r_sq_cnt == 2'd0) begin
               w_state_nxt = IDLE;
            end else begin
               w_sq_cnt_nxt = r_sq_cnt - 2'd1;
            end
         end
         default: begin
            w_state_nxt  = IDLE;
            w_sq_cnt_nxt = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_br_ctrl  <= 1'b0;
         r_br_addr  <= '0;
         r_ret_ctrl <= 1'b0;
         r_ret_pc   <= '0;
         r_irq_ack  <= 1'b0;
         r_in_trap  <= 1'b0;
         r_mepc     <= '0;
         r_last_pc  <= '0;
      end else begin
         r_br_ctrl  <= w_br;
         r_br_addr  <= w_br_addr;
         r_ret_ctrl <= w_ret;
         r_ret_pc   <= w_ret ? r_mepc : '0;
         r_irq_ack  <= w_ack;
         if (w_ack) begin
            r_in_trap <= 1'b1;
            r_mepc    <= bus.ex_valid ? bus.ex_pc : r_last_pc;
         end else if (w_ret) begin
            r_in_trap <= 1'b0;
         end
         // Only slots seen while IDLE are on the architectural path.
         if ((r_state == IDLE) && bus.ex_valid) begin
            r_last_pc <= bus.ex_pc;
         end
      end
   end

   assign bus.br_ctrl  = r_br_ctrl;
   assign bus.br_addr  = r_br_addr;
   assign bus.ret_ctrl = r_ret_ctrl;
   assign bus.ret_pc   = r_ret_pc;
   assign bus.flush    = r_br_ctrl | r_ret_ctrl;
   assign bus.irq_ack  = r_irq_ack;
   assign bus.in_trap  = r_in_trap;

`ifdef PC_REDIRECT_STATS_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_branch_taken <= 32'd0;
         cnt_jump         <= 32'd0;
         cnt_irq          <= 32'd0;
         cnt_mret         <= 32'd0;
      end else begin
         cnt_branch_taken <= sat_inc(cnt_branch_taken, w_ev_branch);
         cnt_jump         <= sat_inc(cnt_jump, w_ev_jump);
         cnt_irq          <= sat_inc(cnt_irq, w_ack);
         cnt_mret         <= sat_inc(cnt_mret, w_ret);
      end
   end
`else
   logic w_unused_ev;
   assign w_unused_ev = w_ev_branch ^ w_ev_jump;
`endif

endmodule

`default_nettype wire
